chess_board_updater: RTL and testbench
======================================

// Module: chess_board_updater
// PURPOSE
//  Holds the 64-square chess board state: a one-hot piece code, an occupancy bit and a colour bit per square.
//  Each enabled clock it applies one move, or takes one move back (undo). Supports captures, castling and en passant.
//  Sits between the move generator/search controller and the evaluation/display logic, which read every square in parallel.
// PARAMETERS
//  none (board fixed at 8x8; square index = rank*8 + file, 0 = a1, 7 = h1, 56 = a8, 63 = h8)
// PORTS
//  clk              in   1   rising-edge clock, single clock domain
//  rst_n            in   1   asynchronous active-low reset
//  color_type       in   1   colour of the moving side: 1 = white, 0 = black
//  enable           in   1   apply the move/undo on this edge
//  clear            in   1   synchronous board wipe
//  init             in   1   synchronous load of the standard start position
//  initialPosition  in   64  one-hot from-square
//  movedPosition    in   64  one-hot to-square
//  movingPiece      in   6   one-hot: 000001 P, 000010 R, 000100 N, 001000 B, 010000 Q, 100000 K
//  capturedPiece    in   6   same code; 000000 = no capture
//  castling         in   2   00 none, 01 queen side, 10 king side
//  enpassant        in   5   00001 or 00000 none, 00010 UL, 00100 UR, 01000 DL, 10000 DR
//  undo             in   1   0 = play the move, 1 = take it back
//  enable_out       out  64  bit i = 1 when square i is occupied
//  color_out        out  64  bit i = colour of the piece on square i (1 white); 0 when the square is empty
//  pieceReg0_out..pieceReg63_out  out  6 each  piece code on square i; 000000 = empty
// BEHAVIOUR
//  - All outputs are registered; an update is visible one clock after its sampling edge.
//  - Reset (rst_n = 0, asynchronous): every pieceReg = 0, enable_out = 0, color_out = 0.
//  - Edge priority: clear > init > enable. With none of these asserted, the board holds.
//  - clear: all squares empty.
//  - init: standard start position.
//      - Ranks 1 and 8 = R N B Q K B N R; ranks 2 and 7 = pawns.
//      - Squares 0-15 are white, 48-63 black; all other squares empty.
//  - Forward move (enable = 1, undo = 0), from-square F, to-square T, colour c = color_type:
//      - F becomes empty; T gets movingPiece with colour c. Any previous content of T is overwritten.
//      - movingPiece is written unchanged, so promotion is done by passing the promoted piece.
//  - Undo (enable = 1, undo = 1):
//      - F gets movingPiece with colour c.
//      - T gets capturedPiece with colour ~c, or becomes empty when capturedPiece = 0.
//  - Castling (01/10) always moves the rook on top of the king move from F to T.
//      - White king side: rook 7 -> 5. White queen side: rook 0 -> 3.
//      - Black king side: rook 63 -> 61. Black queen side: rook 56 -> 59.
//      - Undo returns the rook to its corner.
//  - En passant (UL/UR/DL/DR) ignores capturedPiece.
//      - Victim square E = T-8 for white, T+8 for black.
//      - Forward: E becomes empty.
//      - Undo: E gets a pawn of colour ~c, and T becomes empty.
//  - Invalid inputs: F or T not one-hot, F = T, movingPiece not one-hot, or castling = 11 -> the whole update is ignored and the board holds.
//  - An enpassant value that is not one of the listed codes is treated as none.
//  - enable held high with the same inputs re-applies the same update each edge; a repeated undo is therefore idempotent.
//  - Invariant: enable_out[i] = |pieceReg_i; color_out[i] = 0 whenever square i is empty.
// TESTING
//  - Reset, then init: pieceReg0 = 000010, pieceReg4 = 100000, pieceReg8 = 000001, pieceReg60 = 100000; enable_out = 64'hFFFF00000000FFFF; color_out = 64'h000000000000FFFF.
//  - After init, white e2-e4 (F = 1<<12, T = 1<<28, pawn, undo = 0): pieceReg12 = 0, pieceReg28 = 000001, color_out[28] = 1.
//  - Undo, white pawn F = 1<<49, T = 1<<56, captured rook, enable held 5 cycles: pieceReg49 = 000001 (white), pieceReg56 = 000010 (black, color_out[56] = 0). All other squares are unchanged.
//  - After init, clear squares 5 and 6, then white king 4 -> 6 with castling = 10: pieceReg6 = 100000, pieceReg5 = 000010, squares 4 and 7 empty. Undo restores the original squares.
//  - White pawn on 36, black pawn on 35, white en passant 36 -> 43 (UL): pieceReg43 = 000001, squares 35 and 36 empty. Undo restores the black pawn on 35 and the white pawn on 36, and empties 43.
//  - enable = 0, or F = 0: board unchanged. Assert rst_n mid-run: all outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/chess_board_updater.sv
// Chess board state register: one-hot piece code and colour per square, updated one move
// (or one undo) per enabled clock, including captures, castling and en passant.
module chess_board_updater (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        color_type,
  input  logic        enable,
  input  logic        clear,
  input  logic        init,
  input  logic [63:0] initialPosition,
  input  logic [63:0] movedPosition,
  input  logic [5:0]  movingPiece,
  input  logic [5:0]  capturedPiece,
  input  logic [1:0]  castling,
  input  logic [4:0]  enpassant,
  input  logic        undo,
  output logic [63:0] enable_out,
  output logic [63:0] color_out,
  output logic [5:0]  pieceReg0_out,  pieceReg1_out,  pieceReg2_out,  pieceReg3_out,
  output logic [5:0]  pieceReg4_out,  pieceReg5_out,  pieceReg6_out,  pieceReg7_out,
  output logic [5:0]  pieceReg8_out,  pieceReg9_out,  pieceReg10_out, pieceReg11_out,
  output logic [5:0]  pieceReg12_out, pieceReg13_out, pieceReg14_out, pieceReg15_out,
  output logic [5:0]  pieceReg16_out, pieceReg17_out, pieceReg18_out, pieceReg19_out,
  output logic [5:0]  pieceReg20_out, pieceReg21_out, pieceReg22_out, pieceReg23_out,
  output logic [5:0]  pieceReg24_out, pieceReg25_out, pieceReg26_out, pieceReg27_out,
  output logic [5:0]  pieceReg28_out, pieceReg29_out, pieceReg30_out, pieceReg31_out,
  output logic [5:0]  pieceReg32_out, pieceReg33_out, pieceReg34_out, pieceReg35_out,
  output logic [5:0]  pieceReg36_out, pieceReg37_out, pieceReg38_out, pieceReg39_out,
  output logic [5:0]  pieceReg40_out, pieceReg41_out, pieceReg42_out, pieceReg43_out,
  output logic [5:0]  pieceReg44_out, pieceReg45_out, pieceReg46_out, pieceReg47_out,
  output logic [5:0]  pieceReg48_out, pieceReg49_out, pieceReg50_out, pieceReg51_out,
  output logic [5:0]  pieceReg52_out, pieceReg53_out, pieceReg54_out, pieceReg55_out,
  output logic [5:0]  pieceReg56_out, pieceReg57_out, pieceReg58_out, pieceReg59_out,
  output logic [5:0]  pieceReg60_out, pieceReg61_out, pieceReg62_out, pieceReg63_out
);

  localparam logic [5:0] PcPawn   = 6'b000001;
  localparam logic [5:0] PcRook   = 6'b000010;
  localparam logic [5:0] PcKnight = 6'b000100;
  localparam logic [5:0] PcBishop = 6'b001000;
  localparam logic [5:0] PcQueen  = 6'b010000;
  localparam logic [5:0] PcKing   = 6'b100000;

  // Element [k] is the piece on file k of a back rank (a..h = R N B Q K B N R).
  localparam logic [7:0][5:0] BackRank =
    {PcRook, PcKnight, PcBishop, PcKing, PcQueen, PcBishop, PcKnight, PcRook};

  function automatic logic is_onehot64(input logic [63:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

  function automatic logic is_onehot6(input logic [5:0] v);
    return (v != '0) && ((v & (v - 6'd1)) == '0);
  endfunction

  function automatic logic [5:0] sq_index(input logic [63:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction

  logic [63:0][5:0] r_piece, w_piece_d;
  logic [63:0]      r_color, w_color_d;

  logic       w_valid;
  logic [5:0] w_from;
  logic [5:0] w_to;
  logic       w_castle;
  logic [5:0] w_rook_src;
  logic [5:0] w_rook_dst;
  logic       w_ep_act;
  logic [5:0] w_ep_sq;
  logic       w_ep_ok;

  assign w_valid = is_onehot64(initialPosition) && is_onehot64(movedPosition) &&
                   (initialPosition != movedPosition) && is_onehot6(movingPiece) &&
                   (castling != 2'b11);
  assign w_from  = sq_index(initialPosition);
  assign w_to    = sq_index(movedPosition);

  // Rook corner/target: rank 1 for white, rank 8 for black; king side uses h/f, queen a/d.
  assign w_castle   = (castling == 2'b01) || (castling == 2'b10);
  assign w_rook_src = {{3{~color_type}}, {3{castling[1]}}};
  assign w_rook_dst = {{3{~color_type}}, castling[1], ~castling[1], 1'b1};

  // Captured pawn sits one rank behind the landing square from the mover's viewpoint.
  assign w_ep_act = (enpassant == 5'b00010) || (enpassant == 5'b00100) ||
                    (enpassant == 5'b01000) || (enpassant == 5'b10000);
  assign w_ep_sq  = color_type ? (w_to - 6'd8) : (w_to + 6'd8);
  assign w_ep_ok  = color_type ? (w_to >= 6'd8) : (w_to < 6'd56);

  // Next board: clear > init > enabled move/undo; otherwise hold.
  always_comb begin
    w_piece_d = r_piece;
    w_color_d = r_color;
    if (clear) begin
      w_piece_d = '0;
      w_color_d = '0;
    end else if (init) begin
      w_piece_d = '0;
      for (int i = 0; i < 8; i++) begin
        w_piece_d[i]      = BackRank[i];
        w_piece_d[i + 8]  = PcPawn;
        w_piece_d[i + 48] = PcPawn;
        w_piece_d[i + 56] = BackRank[i];
      end
      w_color_d = 64'h0000_0000_0000_FFFF;
    end else if (enable && w_valid) begin
      if (!undo) begin
        w_piece_d[w_from] = '0;
        w_color_d[w_from] = 1'b0;
        w_piece_d[w_to]   = movingPiece;
        w_color_d[w_to]   = color_type;
        if (w_castle) begin
          w_piece_d[w_rook_src] = '0;
          w_color_d[w_rook_src] = 1'b0;
          w_piece_d[w_rook_dst] = PcRook;
          w_color_d[w_rook_dst] = color_type;
        end
        if (w_ep_act && w_ep_ok) begin
          w_piece_d[w_ep_sq] = '0;
          w_color_d[w_ep_sq] = 1'b0;
        end
      end else begin
        w_piece_d[w_from] = movingPiece;
        w_color_d[w_from] = color_type;
        w_piece_d[w_to]   = capturedPiece;
        w_color_d[w_to]   = ~color_type & (|capturedPiece);
        if (w_castle) begin
          w_piece_d[w_rook_dst] = '0;
          w_color_d[w_rook_dst] = 1'b0;
          w_piece_d[w_rook_src] = PcRook;
          w_color_d[w_rook_src] = color_type;
        end
        if (w_ep_act && w_ep_ok) begin
          w_piece_d[w_to]    = '0;
          w_color_d[w_to]    = 1'b0;
          w_piece_d[w_ep_sq] = PcPawn;
          w_color_d[w_ep_sq] = ~color_type;
        end
      end
    end
  end

  // Board state register with asynchronous wipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_piece <= '0;
      r_color <= '0;
    end else begin
      r_piece <= w_piece_d;
      r_color <= w_color_d;
    end
  end

  // Occupancy is derived from the stored piece codes so it can never disagree with them.
  always_comb begin
    enable_out = '0;
    for (int i = 0; i < 64; i++) begin
      enable_out[i] = |r_piece[i];
    end
  end

  assign color_out = r_color;

  assign pieceReg0_out  = r_piece[0];   assign pieceReg1_out  = r_piece[1];
  assign pieceReg2_out  = r_piece[2];   assign pieceReg3_out  = r_piece[3];
  assign pieceReg4_out  = r_piece[4];   assign pieceReg5_out  = r_piece[5];
  assign pieceReg6_out  = r_piece[6];   assign pieceReg7_out  = r_piece[7];
  assign pieceReg8_out  = r_piece[8];   assign pieceReg9_out  = r_piece[9];
  assign pieceReg10_out = r_piece[10];  assign pieceReg11_out = r_piece[11];
  assign pieceReg12_out = r_piece[12];  assign pieceReg13_out = r_piece[13];
  assign pieceReg14_out = r_piece[14];  assign pieceReg15_out = r_piece[15];
  assign pieceReg16_out = r_piece[16];  assign pieceReg17_out = r_piece[17];
  assign pieceReg18_out = r_piece[18];  assign pieceReg19_out = r_piece[19];
  assign pieceReg20_out = r_piece[20];  assign pieceReg21_out = r_piece[21];
  assign pieceReg22_out = r_piece[22];  assign pieceReg23_out = r_piece[23];
  assign pieceReg24_out = r_piece[24];  assign pieceReg25_out = r_piece[25];
  assign pieceReg26_out = r_piece[26];  assign pieceReg27_out = r_piece[27];
  assign pieceReg28_out = r_piece[28];  assign pieceReg29_out = r_piece[29];
  assign pieceReg30_out = r_piece[30];  assign pieceReg31_out = r_piece[31];
  assign pieceReg32_out = r_piece[32];  assign pieceReg33_out = r_piece[33];
  assign pieceReg34_out = r_piece[34];  assign pieceReg35_out = r_piece[35];
  assign pieceReg36_out = r_piece[36];  assign pieceReg37_out = r_piece[37];
  assign pieceReg38_out = r_piece[38];  assign pieceReg39_out = r_piece[39];
  assign pieceReg40_out = r_piece[40];  assign pieceReg41_out = r_piece[41];
  assign pieceReg42_out = r_piece[42];  assign pieceReg43_out = r_piece[43];
  assign pieceReg44_out = r_piece[44];  assign pieceReg45_out = r_piece[45];
  assign pieceReg46_out = r_piece[46];  assign pieceReg47_out = r_piece[47];
  assign pieceReg48_out = r_piece[48];  assign pieceReg49_out = r_piece[49];
  assign pieceReg50_out = r_piece[50];  assign pieceReg51_out = r_piece[51];
  assign pieceReg52_out = r_piece[52];  assign pieceReg53_out = r_piece[53];
  assign pieceReg54_out = r_piece[54];  assign pieceReg55_out = r_piece[55];
  assign pieceReg56_out = r_piece[56];  assign pieceReg57_out = r_piece[57];
  assign pieceReg58_out = r_piece[58];  assign pieceReg59_out = r_piece[59];
  assign pieceReg60_out = r_piece[60];  assign pieceReg61_out = r_piece[61];
  assign pieceReg62_out = r_piece[62];  assign pieceReg63_out = r_piece[63];

endmodule

// File: tb/tb_chess_board_updater.sv
// Bench for chess_board_updater: directed scenarios plus random moves against a board model.
module tb_chess_board_updater;

  logic        clk;
  logic        rst_n;
  logic        color_type;
  logic        enable;
  logic        clear;
  logic        init;
  logic [63:0] initialPosition;
  logic [63:0] movedPosition;
  logic [5:0]  movingPiece;
  logic [5:0]  capturedPiece;
  logic [1:0]  castling;
  logic [4:0]  enpassant;
  logic        undo;
  logic [63:0] enable_out;
  logic [63:0] color_out;
  logic [5:0]  pr [64];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference board: piece code (0 = empty) and colour (1 = white) per square.
  int m_piece [64];
  int m_color [64];

  chess_board_updater u_dut (
    .clk(clk), .rst_n(rst_n), .color_type(color_type), .enable(enable), .clear(clear),
    .init(init), .initialPosition(initialPosition), .movedPosition(movedPosition),
    .movingPiece(movingPiece), .capturedPiece(capturedPiece), .castling(castling),
    .enpassant(enpassant), .undo(undo), .enable_out(enable_out), .color_out(color_out),
    .pieceReg0_out(pr[0]),   .pieceReg1_out(pr[1]),   .pieceReg2_out(pr[2]),
    .pieceReg3_out(pr[3]),   .pieceReg4_out(pr[4]),   .pieceReg5_out(pr[5]),
    .pieceReg6_out(pr[6]),   .pieceReg7_out(pr[7]),   .pieceReg8_out(pr[8]),
    .pieceReg9_out(pr[9]),   .pieceReg10_out(pr[10]), .pieceReg11_out(pr[11]),
    .pieceReg12_out(pr[12]), .pieceReg13_out(pr[13]), .pieceReg14_out(pr[14]),
    .pieceReg15_out(pr[15]), .pieceReg16_out(pr[16]), .pieceReg17_out(pr[17]),
    .pieceReg18_out(pr[18]), .pieceReg19_out(pr[19]), .pieceReg20_out(pr[20]),
    .pieceReg21_out(pr[21]), .pieceReg22_out(pr[22]), .pieceReg23_out(pr[23]),
    .pieceReg24_out(pr[24]), .pieceReg25_out(pr[25]), .pieceReg26_out(pr[26]),
    .pieceReg27_out(pr[27]), .pieceReg28_out(pr[28]), .pieceReg29_out(pr[29]),
    .pieceReg30_out(pr[30]), .pieceReg31_out(pr[31]), .pieceReg32_out(pr[32]),
    .pieceReg33_out(pr[33]), .pieceReg34_out(pr[34]), .pieceReg35_out(pr[35]),
    .pieceReg36_out(pr[36]), .pieceReg37_out(pr[37]), .pieceReg38_out(pr[38]),
    .pieceReg39_out(pr[39]), .pieceReg40_out(pr[40]), .pieceReg41_out(pr[41]),
    .pieceReg42_out(pr[42]), .pieceReg43_out(pr[43]), .pieceReg44_out(pr[44]),
    .pieceReg45_out(pr[45]), .pieceReg46_out(pr[46]), .pieceReg47_out(pr[47]),
    .pieceReg48_out(pr[48]), .pieceReg49_out(pr[49]), .pieceReg50_out(pr[50]),
    .pieceReg51_out(pr[51]), .pieceReg52_out(pr[52]), .pieceReg53_out(pr[53]),
    .pieceReg54_out(pr[54]), .pieceReg55_out(pr[55]), .pieceReg56_out(pr[56]),
    .pieceReg57_out(pr[57]), .pieceReg58_out(pr[58]), .pieceReg59_out(pr[59]),
    .pieceReg60_out(pr[60]), .pieceReg61_out(pr[61]), .pieceReg62_out(pr[62]),
    .pieceReg63_out(pr[63])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void put(input int sq, input int pc, input int col);
    if (sq >= 0 && sq < 64) begin
      m_piece[sq] = pc;
      m_color[sq] = (pc != 0) ? col : 0;
    end
  endfunction

  function automatic int square_of(input logic [63:0] v);
    int s = -1;
    for (int i = 0; i < 64; i++) if (v[i]) s = i;
    return s;
  endfunction

  function automatic void model_wipe();
    for (int i = 0; i < 64; i++) put(i, 0, 0);
  endfunction

  function automatic void model_step();
    int back [8] = '{2, 4, 8, 16, 32, 8, 4, 2};
    int f, t, c, oc, base, r_src, r_dst, e;
    bit valid, ep;
    if (clear) begin
      model_wipe();
    end else if (init) begin
      model_wipe();
      for (int i = 0; i < 8; i++) begin
        put(i, back[i], 1);
        put(8 + i, 1, 1);
        put(48 + i, 1, 0);
        put(56 + i, back[i], 0);
      end
    end else if (enable) begin
      valid = ($countones(initialPosition) == 1) && ($countones(movedPosition) == 1) &&
              (initialPosition != movedPosition) && ($countones(movingPiece) == 1) &&
              (castling != 2'b11);
      if (valid) begin
        f = square_of(initialPosition);
        t = square_of(movedPosition);
        c = color_type ? 1 : 0;
        oc = 1 - c;
        base = c ? 0 : 56;
        r_src = base + ((castling == 2'b10) ? 7 : 0);
        r_dst = base + ((castling == 2'b10) ? 5 : 3);
        ep = (enpassant == 5'd2) || (enpassant == 5'd4) || (enpassant == 5'd8) ||
             (enpassant == 5'd16);
        e = c ? t - 8 : t + 8;
        if (!undo) begin
          put(f, 0, 0);
          put(t, int'(movingPiece), c);
          if (castling != 2'b00) begin
            put(r_src, 0, 0);
            put(r_dst, 2, c);
          end
          if (ep) put(e, 0, 0);
        end else begin
          put(f, int'(movingPiece), c);
          put(t, int'(capturedPiece), oc);
          if (castling != 2'b00) begin
            put(r_dst, 0, 0);
            put(r_src, 2, c);
          end
          if (ep && e >= 0 && e < 64) begin
            put(t, 0, 0);
            put(e, 1, oc);
          end
        end
      end
    end
  endfunction

  function automatic logic [383:0] dut_pieces();
    logic [383:0] v;
    for (int i = 0; i < 64; i++) v[i*6 +: 6] = pr[i];
    return v;
  endfunction

  function automatic logic [383:0] exp_pieces();
    logic [383:0] v;
    for (int i = 0; i < 64; i++) v[i*6 +: 6] = 6'(m_piece[i]);
    return v;
  endfunction

  task automatic compare_all(input string tag);
    logic [63:0] occ, col;
    for (int i = 0; i < 64; i++) begin
      occ[i] = (m_piece[i] != 0);
      col[i] = (m_color[i] != 0);
    end
    check({tag, ".pieces"}, dut_pieces(), exp_pieces());
    check({tag, ".enable_out"}, {320'd0, enable_out}, {320'd0, occ});
    check({tag, ".color_out"}, {320'd0, color_out}, {320'd0, col});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step();
    compare_all(tag);
  endtask

  task automatic idle();
    enable = 1'b0; clear = 1'b0; init = 1'b0; undo = 1'b0; color_type = 1'b1;
    initialPosition = '0; movedPosition = '0; movingPiece = '0; capturedPiece = '0;
    castling = '0; enpassant = '0;
  endtask

  task automatic set_move(input logic c, input int f, input int t, input logic [5:0] mp,
                          input logic [5:0] cap, input logic [1:0] cs, input logic [4:0] ep,
                          input logic u);
    idle();
    enable = 1'b1; color_type = c; undo = u;
    initialPosition = 64'd1 << f; movedPosition = 64'd1 << t;
    movingPiece = mp; capturedPiece = cap; castling = cs; enpassant = ep;
  endtask

  initial begin
    logic [63:0] r;
    idle();
    rst_n = 1'b0;
    model_wipe();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Start position.
    init = 1'b1;
    tick("init");
    check("init.sq0", {378'd0, pr[0]}, 384'h02);
    check("init.sq4", {378'd0, pr[4]}, 384'h20);
    check("init.sq8", {378'd0, pr[8]}, 384'h01);
    check("init.sq60", {378'd0, pr[60]}, 384'h20);
    check("init.occ", {320'd0, enable_out}, {320'd0, 64'hFFFF00000000FFFF});
    check("init.col", {320'd0, color_out}, {320'd0, 64'h000000000000FFFF});

    // e2-e4.
    set_move(1'b1, 12, 28, 6'b000001, 6'b0, 2'b00, 5'b0, 1'b0);
    tick("e2e4");
    check("e2e4.sq12", {378'd0, pr[12]}, 384'h0);
    check("e2e4.sq28", {378'd0, pr[28]}, 384'h01);
    check("e2e4.col28", {383'd0, color_out[28]}, 384'h1);

    // Undo held for several edges must not drift.
    set_move(1'b1, 49, 56, 6'b000001, 6'b000010, 2'b00, 5'b0, 1'b1);
    for (int k = 0; k < 5; k++) tick("undo_hold");
    check("undo.sq49", {378'd0, pr[49]}, 384'h01);
    check("undo.col49", {383'd0, color_out[49]}, 384'h1);
    check("undo.sq56", {378'd0, pr[56]}, 384'h02);
    check("undo.col56", {383'd0, color_out[56]}, 384'h0);

    // White king-side castle after vacating f1/g1.
    idle(); init = 1'b1; tick("cs_init");
    set_move(1'b1, 5, 20, 6'b001000, 6'b0, 2'b00, 5'b0, 1'b0); tick("cs_vac5");
    set_move(1'b1, 6, 21, 6'b000100, 6'b0, 2'b00, 5'b0, 1'b0); tick("cs_vac6");
    set_move(1'b1, 4, 6, 6'b100000, 6'b0, 2'b10, 5'b0, 1'b0); tick("castle");
    check("castle.sq6", {378'd0, pr[6]}, 384'h20);
    check("castle.sq5", {378'd0, pr[5]}, 384'h02);
    check("castle.sq4_7", {376'd0, pr[4], pr[7]}, 384'h0);
    undo = 1'b1; tick("castle_undo");
    check("castle_undo.sq4", {378'd0, pr[4]}, 384'h20);
    check("castle_undo.sq7", {378'd0, pr[7]}, 384'h02);
    check("castle_undo.sq5_6", {376'd0, pr[5], pr[6]}, 384'h0);

    // En passant: place pawns through undo writes, then capture and take back.
    idle(); clear = 1'b1; tick("ep_clear");
    set_move(1'b1, 36, 0, 6'b000001, 6'b0, 2'b00, 5'b0, 1'b1); tick("ep_place_w");
    set_move(1'b0, 35, 0, 6'b000001, 6'b0, 2'b00, 5'b0, 1'b1); tick("ep_place_b");
    set_move(1'b1, 36, 43, 6'b000001, 6'b0, 2'b00, 5'b00010, 1'b0); tick("ep");
    check("ep.sq43", {378'd0, pr[43]}, 384'h01);
    check("ep.sq35_36", {376'd0, pr[35], pr[36]}, 384'h0);
    undo = 1'b1; tick("ep_undo");
    check("ep_undo.sq35", {377'd0, pr[35], color_out[35]}, {377'd0, 6'b000001, 1'b0});
    check("ep_undo.sq36", {377'd0, pr[36], color_out[36]}, {377'd0, 6'b000001, 1'b1});
    check("ep_undo.sq43", {378'd0, pr[43]}, 384'h0);

    // Hold cases.
    idle(); init = 1'b1; tick("hold_init");
    set_move(1'b1, 12, 28, 6'b000001, 6'b0, 2'b00, 5'b0, 1'b0);
    enable = 1'b0; tick("hold_en0");
    enable = 1'b1; initialPosition = '0; tick("hold_f0");

    // Random traffic, including malformed moves and occasional clear/init.
    for (int n = 0; n < 400; n++) begin
      idle();
      enable = ($urandom_range(0, 4) != 0);
      clear = ($urandom_range(0, 39) == 0);
      init = ($urandom_range(0, 19) == 0);
      color_type = 1'($urandom);
      undo = 1'($urandom);
      initialPosition = 64'd1 << $urandom_range(0, 63);
      movedPosition = 64'd1 << $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) initialPosition = '0;
      if ($urandom_range(0, 9) == 0) begin
        r = 64'd1 << $urandom_range(0, 63);
        movedPosition = movedPosition | r;
      end
      movingPiece = 6'd1 << $urandom_range(0, 5);
      if ($urandom_range(0, 9) == 0) movingPiece = 6'($urandom);
      capturedPiece = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'd1 << $urandom_range(0, 5);
      castling = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      enpassant = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b00000;
      tick("rand");
    end

    // Asynchronous reset between edges.
    idle(); init = 1'b1; tick("ar_init");
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    model_wipe();
    compare_all("async_rst");
    #1;
    rst_n = 1'b1;
    tick("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
